// File: rtl/stack_mp.sv
`default_nettype none
// ============================================================================
//  Module   : stack_mp
//  Brief    : Multi-port byte-enabled stack memory with collision resolution,
//             optional write-to-read forwarding, range checking and zero sweep.
//  Revision : 1.0
// ============================================================================
module stack_mp #(
    parameter int VALUE_SIZE  = 64,
    parameter int MAX_ENTRIES = 64,
    parameter int NRPORTS     = 4,
    parameter int NWPORTS     = 4,
    parameter int RDW         = 0
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [NRPORTS*64-1:0]             read_add,
    output logic [NRPORTS*VALUE_SIZE-1:0]     data_out,
    input  logic [NWPORTS*64-1:0]             wrt_add,
    input  logic [NWPORTS-1:0]                wrt_en,
    input  logic [NWPORTS*(VALUE_SIZE/8)-1:0] wrt_be,
    input  logic [NWPORTS*VALUE_SIZE-1:0]     data_in,
    input  logic                              clr,
    output logic                              busy,
    output logic [NRPORTS-1:0]                rd_err,
    output logic                              err
);

    localparam int          BE      = VALUE_SIZE / 8;
    localparam int          AW      = (MAX_ENTRIES > 1) ? $clog2(MAX_ENTRIES) : 1;
    localparam logic [63:0] c_LIMIT = 64'(MAX_ENTRIES);
    localparam logic [AW-1:0] c_LAST = AW'(MAX_ENTRIES - 1);

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_CLEAR = 1'b1
    } state_t;

    state_t                  r_state;
    logic [AW-1:0]           r_ptr;
    logic                    r_err;
    logic [VALUE_SIZE-1:0]   r_mem [MAX_ENTRIES];

    logic                    w_busy;
    logic [NWPORTS-1:0]      w_wr_inr;
    logic [NWPORTS-1:0]      w_wr_go;
    logic [AW-1:0]           w_wa [NWPORTS];
    logic [NRPORTS-1:0]      w_rd_inr;
    logic                    w_any_err;

    assign w_busy = (r_state == S_CLEAR);
    assign busy   = w_busy;
    assign err    = r_err;

    // Full 64-bit compare so high address bits can never alias into range.
    generate
        for (genvar p = 0; p < NWPORTS; p++) begin : g_wr
            assign w_wr_inr[p] = (wrt_add[p*64 +: 64] < c_LIMIT);
            assign w_wa[p]     = wrt_add[p*64 +: AW];
            assign w_wr_go[p]  = wrt_en[p] & w_wr_inr[p] & ~w_busy & ~reset;
        end
    endgenerate

    assign w_any_err = (|(~w_rd_inr)) | (|(wrt_en & ~w_wr_inr));

    // Sweep FSM: a restart (reset or clr) always begins again at word 0.
    always_ff @(posedge clk) begin
        if (reset || clr) begin
            r_state <= S_CLEAR;
            r_ptr   <= '0;
        end else if (r_state == S_CLEAR) begin
            if (r_ptr == c_LAST) begin
                r_state <= S_IDLE;
            end
            r_ptr <= r_ptr + AW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            r_err <= 1'b0;
        end else if (!w_busy && w_any_err) begin
            r_err <= 1'b1;
        end
    end

    // Ports are applied in ascending order so the highest port owns each byte.
    always_ff @(posedge clk) begin
        if (w_busy) begin
            r_mem[r_ptr] <= '0;
        end else begin
            for (int p = 0; p < NWPORTS; p++) begin
                for (int b = 0; b < BE; b++) begin
                    if (w_wr_go[p] && wrt_be[p*BE + b]) begin
                        r_mem[w_wa[p]][b*8 +: 8] <= data_in[p*VALUE_SIZE + b*8 +: 8];
                    end
                end
            end
        end
    end

    generate
        for (genvar i = 0; i < NRPORTS; i++) begin : g_rd
            logic [AW-1:0]         w_ra;
            logic [VALUE_SIZE-1:0] w_word;
            logic [VALUE_SIZE-1:0] r_dout;
            logic                  r_rerr;

            assign w_rd_inr[i] = (read_add[i*64 +: 64] < c_LIMIT);
            assign w_ra        = read_add[i*64 +: AW];

            if (RDW != 0) begin : g_fwd
                // Merge this edge's writes using the same port-priority order.
                always_comb begin
                    w_word = r_mem[w_ra];
                    for (int p = 0; p < NWPORTS; p++) begin
                        for (int b = 0; b < BE; b++) begin
                            if (w_wr_go[p] && wrt_be[p*BE + b] && (w_wa[p] == w_ra)) begin
                                w_word[b*8 +: 8] = data_in[p*VALUE_SIZE + b*8 +: 8];
                            end
                        end
                    end
                end
            end else begin : g_nofwd
                assign w_word = r_mem[w_ra];
            end

            always_ff @(posedge clk) begin
                if (reset || w_busy) begin
                    r_dout <= '0;
                    r_rerr <= 1'b0;
                end else if (!w_rd_inr[i]) begin
                    r_dout <= '0;
                    r_rerr <= 1'b1;
                end else begin
                    r_dout <= w_word;
                    r_rerr <= 1'b0;
                end
            end

            assign data_out[i*VALUE_SIZE +: VALUE_SIZE] = r_dout;
            assign rd_err[i]                            = r_rerr;
        end
    endgenerate

endmodule
`default_nettype wire

// File: doc/stack_mp.md
# stack_mp

Parametrised multi-port stack memory for the Sephirot eBPF core, generalising the fixed 4R/4W 64×64 stack. Each VLIW lane gets a read and a write port; writes carry byte enables so 1/2/4/8-byte eBPF stores go straight to the stack without read-modify-write. The block deterministically resolves same-cycle write collisions, optionally forwards same-cycle writes to reads, flags out-of-range accesses, and runs a hardware zero-fill sweep at reset and on request between packets.

## Interface
- VALUE_SIZE, 64, word width in bits; multiple of 8
- MAX_ENTRIES, 64, word count; power of 2, ≥2
- NRPORTS, 4, read ports
- NWPORTS, 4, write ports
- RDW, 0, 0 = read returns pre-write data; 1 = same-cycle write forwarded to read
- BE = VALUE_SIZE/8 (derived); AW = $clog2(MAX_ENTRIES) (derived)

- clk  in  1  clock; all logic on rising edge
- reset  in  1  synchronous, active-high
- read_add  in  NRPORTS*64  word addresses; port i at [i*64 +: 64]
- data_out  out  NRPORTS*VALUE_SIZE  registered read data; port i at [i*VALUE_SIZE +: VALUE_SIZE]
- wrt_add  in  NWPORTS*64  word addresses
- wrt_en  in  NWPORTS  per-port write enable
- wrt_be  in  NWPORTS*BE  per-port byte enables; bit 0 = bits [7:0]
- data_in  in  NWPORTS*VALUE_SIZE  write data
- clr  in  1  one-cycle pulse; start zero-fill sweep
- busy  out  1  sweep in progress
- rd_err  out  NRPORTS  registered, per port: this cycle's returned read was out of range
- err  out  1  sticky: any out-of-range read or write since last reset/clr

## Operation
- Address in range iff read_add/wrt_add < MAX_ENTRIES (all 64 bits compared, not truncated).
- Write: at edge, for each port with wrt_en=1, in range, busy=0: byte b of word updated iff wrt_be[b]=1. wrt_en=1 with wrt_be=0 is a legal no-op.
- Collision: several ports write same byte of same word in a cycle → highest-numbered port wins, per byte. Different bytes of one word from different ports all land.
- Out-of-range write: dropped, err set. Out-of-range read: data_out=0, rd_err[i]=1, err set.
- Read: data_out[i] registered from read_add[i] sampled at the edge.
  - RDW=0: value is memory content before that edge's writes.
  - RDW=1: value includes that edge's writes (merged bytes, collision rule applied).
- Sweep FSM, states CLEAR and IDLE:
  - reset=1 → CLEAR, ptr=0.
  - CLEAR: each edge writes zero to word ptr, ptr++; edge writing MAX_ENTRIES-1 → IDLE.
  - IDLE: clr=1 → CLEAR, ptr=0.
  - CLEAR + clr=1: restart at ptr=0.
- busy=1 exactly while in CLEAR. During busy: all port writes ignored (no err), data_out=0, rd_err=0.
- clr also clears err (same edge; an error in that cycle is dropped).

## Timing
- Reset values: data_out=0, rd_err=0, err=0, busy=1 (CLEAR, ptr=0).
- busy high for exactly MAX_ENTRIES cycles after the first edge with reset=0; first edge after clr in IDLE raises busy for MAX_ENTRIES cycles.
- Read latency 1 cycle; write visible to a read issued the next cycle (either RDW).
- Reset asserted mid-sweep or mid-operation: restarts sweep from 0; port writes that edge dropped.
- Memory contents undefined only until first sweep completes; never visible since reads return 0 while busy.
- No backpressure; all ports accepted every cycle when busy=0.

## Test plan
- Reset, release, count busy cycles → busy high 64 cycles; then read all 64 words on 4 ports → all 0, err=0.
- Port 2 writes 0x1122334455667788 to addr 5, be=0xFF; next cycle port 0 reads 5 → 0x1122334455667788 one cycle later.
- Same cycle: port 0 writes addr 3 data all-0xAA be=0xFF, port 3 writes addr 3 all-0x55 be=0x0F → word 3 = 0xAAAAAAAA55555555.
- RDW=0 vs RDW=1: addr 7 holds 0, write 0xDEAD be=0x03 while port 1 reads 7 same cycle → 0 (RDW=0) / 0xDEAD (RDW=1).
- Read addr 64 and write addr 0x1_0000_0000 → data_out=0, rd_err[i]=1, err=1, memory unchanged; clr clears err.
- Fill memory with nonzero, pulse clr, pulse clr again 10 cycles in → busy lasts 10+64 cycles, all words 0 after; writes during busy have no effect.
